mem_arbiter: RTL and testbench

Single-port memory arbiter placed between the core's requesters and the unified instruction/data memory. It shares the memory between a debug/loader port, the load/store unit and instruction fetch using fixed priority with anti-starvation for fetch. It tracks exactly one outstanding access and returns each response on a valid/ready channel, with a holding register when the requester stalls. riscv-tests runs such as rv32ui-p-sb depend on it for byte-enabled stores interleaved with fetch.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_rsp_buf.sv | 71 +++++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: requester IDs, response FSM states, default starvation limit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Requester IDs double as bit positions in the per-requester vectors.
    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_DBG  = 2'd0;
    localparam req_id_t REQ_DMEM = 2'd1;
    localparam req_id_t REQ_IMEM = 2'd2;
    localparam int      NUM_REQ  = 3;

    // IDLE: nothing outstanding, RESP: first response cycle (data from memory),
    // HOLD: response stalled (data from the holding register).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arb_rsp_buf.sv
// Response tracker for the single outstanding access: owner/we registers, hold register, RESP/HOLD data select.
// Latency: response valid the cycle after grant; data straight from mem_rdata in RESP, from hold_q in HOLD.
// Backpressure: an unaccepted response parks mem_rdata in hold_q and stays valid until its owner takes it.
// Ports: grant/grant_id/grant_we   - access launched this cycle (only when idle or accept is high)
//        mem_rdata                 - memory read data, valid the cycle after the strobe
//        rsp_ready/rsp_valid       - per-requester response handshake, indexed by req_id_t
//        rsp_rdata                 - shared response data (0 for writes)
//        idle/accept               - no access outstanding / current response taken this cycle
module mem_arb_rsp_buf
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               grant,
    input  req_id_t            grant_id,
    input  logic               grant_we,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic [NUM_REQ-1:0] rsp_ready,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               idle,
    output logic               accept
);

    arb_state_t        state;
    logic              we_q;
    logic [DATA_W-1:0] hold_q;

    // rsp_valid is the owner register kept one-hot, so it is also the
    // registered response-valid output.
    assign accept = |(rsp_valid & rsp_ready);
    assign idle   = (state == IDLE);

    always_comb begin
        rsp_rdata = '0;
        if (!we_q) begin
            if (state == RESP) begin
                rsp_rdata = mem_rdata;
            end else if (state == HOLD) begin
                rsp_rdata = hold_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rsp_valid <= '0;
            we_q      <= 1'b0;
            hold_q    <= '0;
        end else begin
            if (grant) begin
                // A grant only happens when idle or when the current
                // response retires this cycle, so it simply replaces it.
                state     <= RESP;
                rsp_valid <= NUM_REQ'(1) << grant_id;
                we_q      <= grant_we;
            end else if (accept) begin
                state     <= IDLE;
                rsp_valid <= '0;
            end else if (state == RESP) begin
                // mem_rdata is only guaranteed for one cycle; park it.
                state  <= HOLD;
                hold_q <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: dbg > dmem > imem, fetch promoted over dmem after STARVE_LIMIT denied cycles.
// Latency: grant/strobe combinational in cycle N, response valid in N+1; 1 access/cycle when responses are taken at once.
// Backpressure: one access outstanding; a stalled response holds its data and blocks every grant until accepted.
// Ports: <req>_valid/_ready/_addr/_we/_be/_wdata - request channels (imem is read-only)
//        <req>_rsp_valid/_rsp_ready, rsp_rdata   - response channels sharing one data bus
//        mem_en/we/be/addr/wdata, mem_rdata      - memory port, read data one cycle after mem_en
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dbg_valid,
    input  logic                  dmem_valid,
    input  logic                  imem_valid,
    output logic                  dbg_ready,
    output logic                  dmem_ready,
    output logic                  imem_ready,
    input  logic [ADDR_W-1:0]     dbg_addr,
    input  logic [ADDR_W-1:0]     dmem_addr,
    input  logic [ADDR_W-1:0]     imem_addr,
    input  logic                  dbg_we,
    input  logic                  dmem_we,
    input  logic [DATA_W/8-1:0]   dbg_be,
    input  logic [DATA_W/8-1:0]   dmem_be,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [DATA_W-1:0]     dmem_wdata,
    output logic                  dbg_rsp_valid,
    output logic                  dmem_rsp_valid,
    output logic                  imem_rsp_valid,
    input  logic                  dbg_rsp_ready,
    input  logic                  dmem_rsp_ready,
    input  logic                  imem_rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]   starve_cnt;
    logic               promote;
    logic               idle;
    logic               accept;
    logic               grant_ok;
    logic               win_vld;
    req_id_t            win_id;
    logic               grant;
    logic [NUM_REQ-1:0] rsp_ready_vec;
    logic [NUM_REQ-1:0] rsp_valid_vec;

    assign promote = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Gating with rst keeps every ready and the strobe low while in reset.
    assign grant_ok = rst & (idle | accept);

    always_comb begin
        win_vld = 1'b1;
        win_id  = REQ_DBG;
        if (dbg_valid) begin
            win_id = REQ_DBG;
        end else if (promote && imem_valid) begin
            win_id = REQ_IMEM;
        end else if (dmem_valid) begin
            win_id = REQ_DMEM;
        end else if (imem_valid) begin
            win_id = REQ_IMEM;
        end else begin
            win_vld = 1'b0;
        end
    end

    assign grant      = grant_ok & win_vld;
    assign dbg_ready  = grant & (win_id == REQ_DBG);
    assign dmem_ready = grant & (win_id == REQ_DMEM);
    assign imem_ready = grant & (win_id == REQ_IMEM);

    // Memory port follows the winner in the grant cycle, zero otherwise.
    always_comb begin
        mem_en    = grant;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant) begin
            case (win_id)
                REQ_DBG: begin
                    mem_we    = dbg_we;
                    mem_be    = dbg_be;
                    mem_addr  = dbg_addr;
                    mem_wdata = dbg_wdata;
                end
                REQ_DMEM: begin
                    mem_we    = dmem_we;
                    mem_be    = dmem_be;
                    mem_addr  = dmem_addr;
                    mem_wdata = dmem_wdata;
                end
                default: begin
                    mem_be   = '1;
                    mem_addr = imem_addr;
                end
            endcase
        end
    end

    // Counts consecutive cycles fetch waits; any gap in imem_valid restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!imem_valid || imem_ready) begin
            starve_cnt <= '0;
        end else if (!promote) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign rsp_ready_vec = {imem_rsp_ready, dmem_rsp_ready, dbg_rsp_ready};

    mem_arb_rsp_buf #(
        .DATA_W (DATA_W)
    ) u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .grant     (grant),
        .grant_id  (win_id),
        .grant_we  (mem_we),
        .mem_rdata (mem_rdata),
        .rsp_ready (rsp_ready_vec),
        .rsp_valid (rsp_valid_vec),
        .rsp_rdata (rsp_rdata),
        .idle      (idle),
        .accept    (accept)
    );

    assign dbg_rsp_valid  = rsp_valid_vec[REQ_DBG];
    assign dmem_rsp_valid = rsp_valid_vec[REQ_DMEM];
    assign imem_rsp_valid = rsp_valid_vec[REQ_IMEM];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, checked against a transaction-level model.
// Latency: n/a.
// Backpressure: response readies are driven directly and randomised in the random phase.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Requester drive, indexed 0=dbg 1=dmem 2=imem.
    logic        r_vld   [3];
    logic [15:0] r_addr  [3];
    logic        r_we    [3];
    logic [3:0]  r_be    [3];
    logic [31:0] r_wdata [3];
    logic        r_rrdy  [3];

    logic        dbg_ready, dmem_ready, imem_ready;
    logic        dbg_rsp_valid, dmem_rsp_valid, imem_rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .dbg_valid(r_vld[0]), .dmem_valid(r_vld[1]), .imem_valid(r_vld[2]),
        .dbg_ready(dbg_ready), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .dbg_addr(r_addr[0]), .dmem_addr(r_addr[1]), .imem_addr(r_addr[2]),
        .dbg_we(r_we[0]), .dmem_we(r_we[1]),
        .dbg_be(r_be[0]), .dmem_be(r_be[1]),
        .dbg_wdata(r_wdata[0]), .dmem_wdata(r_wdata[1]),
        .dbg_rsp_valid(dbg_rsp_valid), .dmem_rsp_valid(dmem_rsp_valid), .imem_rsp_valid(imem_rsp_valid),
        .dbg_rsp_ready(r_rrdy[0]), .dmem_rsp_ready(r_rrdy[1]), .imem_rsp_ready(r_rrdy[2]),
        .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input logic [15:0] a);
        return 32'hA5C3_0000 | {16'h0, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        return w;
    endfunction

    // Memory environment: synchronous SRAM with byte enables, read data one cycle after mem_en.
    logic [31:0] ram [256];
    bit          ram_wr [256];
    logic [31:0] ram_q   = '0;
    logic [31:0] perturb = '0;
    assign mem_rdata = ram_q ^ perturb;

    function automatic logic [31:0] ram_rd(input logic [15:0] a);
        return ram_wr[a[7:0]] ? ram[a[7:0]] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            ram_q <= ram_rd(mem_addr);
            if (mem_we) begin
                ram[mem_addr[7:0]]    <= merge(ram_rd(mem_addr), mem_wdata, mem_be);
                ram_wr[mem_addr[7:0]] <= 1'b1;
            end
        end
    end

    // Reference model: one outstanding transaction, expected data fixed at grant time.
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    int          m_starve = 0;
    bit          m_out    = 0;
    int          m_owner  = 0;
    logic [31:0] m_data   = '0;
    bit          m_acc    = 0;
    int          m_win    = -1;

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : init_word(a);
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs applied; compares the DUT to the model.
    task automatic eval();
        logic [2:0] rdy;
        logic [2:0] rv;
        #1;
        if (!rst) begin
            m_out    = 0;
            m_starve = 0;
        end
        m_acc = m_out && r_rrdy[m_owner];
        m_win = -1;
        if (rst && (!m_out || m_acc)) begin
            if (r_vld[0])                         m_win = 0;
            else if (m_starve == LIMIT && r_vld[2]) m_win = 2;
            else if (r_vld[1])                    m_win = 1;
            else if (r_vld[2])                    m_win = 2;
        end
        rdy = {imem_ready, dmem_ready, dbg_ready};
        rv  = {imem_rsp_valid, dmem_rsp_valid, dbg_rsp_valid};
        for (int r = 0; r < 3; r++) begin
            check($sformatf("ready[%0d]", r), 32'(rdy[r]), 32'(m_win == r));
            check($sformatf("rsp_valid[%0d]", r), 32'(rv[r]), 32'(m_out && m_owner == r));
        end
        check("mem_en", 32'(mem_en), 32'(m_win >= 0));
        if (m_out) check("rsp_rdata", rsp_rdata, m_data);
        if (m_win >= 0) begin
            check("mem_addr", 32'(mem_addr), 32'(r_addr[m_win]));
            if (m_win == 2) begin
                check("mem_we_imem", 32'(mem_we), 32'h0);
                check("mem_be_imem", 32'(mem_be), 32'hF);
            end else begin
                check("mem_we", 32'(mem_we), 32'(r_we[m_win]));
                check("mem_be", 32'(mem_be), 32'(r_be[m_win]));
                if (r_we[m_win]) check("mem_wdata", mem_wdata, r_wdata[m_win]);
            end
        end
    endtask

    // Advances the model across the rising edge and returns at the next falling edge.
    task automatic tick();
        if (m_acc) m_out = 0;
        if (m_win >= 0) begin
            m_out   = 1;
            m_owner = m_win;
            if (m_win != 2 && r_we[m_win]) begin
                m_data = '0;
                ref_mem[r_addr[m_win][7:0]] = merge(ref_rd(r_addr[m_win]), r_wdata[m_win], r_be[m_win]);
                ref_wr[r_addr[m_win][7:0]]  = 1'b1;
            end else begin
                m_data = ref_rd(r_addr[m_win]);
            end
        end
        if (!rst || !r_vld[2] || m_win == 2) m_starve = 0;
        else if (m_starve < LIMIT)          m_starve++;
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic v, input logic [15:0] a, input logic w,
                           input logic [3:0] be, input logic [31:0] d);
        r_vld[r] = v; r_addr[r] = a; r_we[r] = w; r_be[r] = be; r_wdata[r] = d;
    endtask

    initial begin
        for (int r = 0; r < 3; r++) begin
            set_req(r, 1'b1, 16'h0020 + 16'(r), 1'b0, 4'hF, 32'h0);
            r_rrdy[r] = 1'b1;
        end
        @(negedge clk);

        // Reset with every requester asking.
        eval();
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_ready", 32'({dbg_ready, dmem_ready, imem_ready}), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_valid", 32'({dbg_rsp_valid, dmem_rsp_valid, imem_rsp_valid}), 32'h0);
        tick();
        rst = 1'b1;
        eval();
        check("first_grant_dbg", 32'(dbg_ready), 32'h1);
        tick();
        for (int r = 0; r < 3; r++) r_vld[r] = 1'b0;
        eval(); tick();

        // dmem byte write, then fetch of the same word.
        set_req(1, 1'b1, 16'h0010, 1'b1, 4'b0001, 32'h0000_00AB);
        eval();
        check("wr_dmem_ready", 32'(dmem_ready), 32'h1);
        check("wr_mem_we", 32'(mem_we), 32'h1);
        check("wr_mem_be", 32'(mem_be), 32'h1);
        tick();
        r_vld[1] = 1'b0;
        eval();
        check("wr_rsp_valid", 32'(dmem_rsp_valid), 32'h1);
        check("wr_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        set_req(2, 1'b1, 16'h0010, 1'b0, 4'hF, 32'h0);
        eval(); tick();
        r_vld[2] = 1'b0;
        eval();
        check("rd_imem_rsp_valid", 32'(imem_rsp_valid), 32'h1);
        check("rd_imem_rdata", rsp_rdata, 32'hA5C3_00AB);
        tick();

        // Fetch starvation: dmem x4, imem, dmem.
        set_req(1, 1'b1, 16'h0001, 1'b0, 4'hF, 32'h0);
        set_req(2, 1'b1, 16'h0002, 1'b0, 4'hF, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            eval();
            check($sformatf("starve_dmem_c%0d", c), 32'(dmem_ready), 32'(c != 5));
            check($sformatf("starve_imem_c%0d", c), 32'(imem_ready), 32'(c == 5));
            tick();
        end
        r_vld[1] = 1'b0; r_vld[2] = 1'b0;
        eval(); tick();

        // Stalled fetch response with memory data moving underneath.
        set_req(2, 1'b1, 16'h0003, 1'b0, 4'hF, 32'h0);
        r_rrdy[2] = 1'b0;
        eval(); tick();
        r_vld[2] = 1'b0;
        set_req(1, 1'b1, 16'h0004, 1'b0, 4'hF, 32'h0);
        for (int s = 1; s <= 3; s++) begin
            eval();
            check($sformatf("stall_rdata_s%0d", s), rsp_rdata, 32'hA5C3_0003);
            check($sformatf("stall_no_ready_s%0d", s), 32'({dbg_ready, dmem_ready, imem_ready}), 32'h0);
            tick();
            perturb = 32'hFFFF_0000;
        end
        r_rrdy[2] = 1'b1;
        eval();
        check("stall_accept_rdata", rsp_rdata, 32'hA5C3_0003);
        check("stall_accept_grant", 32'(dmem_ready), 32'h1);
        tick();
        perturb  = '0;
        r_vld[1] = 1'b0;
        eval(); tick();

        // Back-to-back dmem reads 0..3.
        for (int k = 0; k <= 4; k++) begin
            set_req(1, k < 4, 16'(k), 1'b0, 4'hF, 32'h0);
            eval();
            if (k < 4) check($sformatf("b2b_ready_%0d", k), 32'(dmem_ready), 32'h1);
            if (k > 0) begin
                check($sformatf("b2b_rsp_valid_%0d", k), 32'(dmem_rsp_valid), 32'h1);
                check($sformatf("b2b_rdata_%0d", k), rsp_rdata, 32'hA5C3_0000 | 32'(k - 1));
            end
            tick();
        end

        // Reset while a fetch response is held.
        set_req(2, 1'b1, 16'h0005, 1'b0, 4'hF, 32'h0);
        r_rrdy[2] = 1'b0;
        eval(); tick();
        r_vld[2] = 1'b0;
        eval(); tick();
        eval();
        check("hold_before_rst", 32'(imem_rsp_valid), 32'h1);
        tick();
        rst = 1'b0;
        eval();
        check("hold_rst_rsp_valid", 32'({dbg_rsp_valid, dmem_rsp_valid, imem_rsp_valid}), 32'h0);
        tick();
        rst = 1'b1;
        r_rrdy[2] = 1'b1;
        eval();
        check("hold_no_stale", 32'({dbg_rsp_valid, dmem_rsp_valid, imem_rsp_valid}), 32'h0);
        tick();

        // A strobed write survives a reset during its response.
        set_req(0, 1'b1, 16'h0020, 1'b1, 4'hF, 32'hDEAD_BEEF);
        eval(); tick();
        r_vld[0] = 1'b0;
        rst = 1'b0;
        eval(); tick();
        rst = 1'b1;
        set_req(0, 1'b1, 16'h0020, 1'b0, 4'hF, 32'h0);
        eval(); tick();
        r_vld[0] = 1'b0;
        eval();
        check("wr_commit_rdata", rsp_rdata, 32'hDEAD_BEEF);
        tick();

        // Random traffic; an ungranted request keeps its fields or is withdrawn.
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (r_vld[r] && m_win != r) begin
                    if ($urandom_range(7) == 0) r_vld[r] = 1'b0;
                end else begin
                    set_req(r, 1'($urandom_range(1)), 16'($urandom_range(15)),
                            (r != 2) && ($urandom_range(1) == 1),
                            4'($urandom_range(15, 1)), $urandom);
                end
                r_rrdy[r] = ($urandom_range(3) != 0);
            end
            eval(); tick();
        end
        for (int r = 0; r < 3; r++) begin
            r_vld[r]  = 1'b0;
            r_rrdy[r] = 1'b1;
        end
        eval(); tick();
        eval(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
